rca_seq_adder: RTL and testbench

//  Parametrised multi-cycle ripple-carry adder/subtractor with a ready/valid handshake.

---
 rtl/rca_seq_adder.sv | 137 +++++++++++++
 tb/tb_rca_seq_adder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_adder.sv
// Multi-cycle ripple-carry adder/subtractor: adds one CHUNK-bit slice per cycle, LSB slice first.
// Latency: out_valid rises NSTEP = WIDTH/CHUNK edges after the accepting edge; NSTEP+2 cycles per op at best.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, inputs ignored meanwhile.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, cin, sub)
//   sub                   0: sum = a + b + cin ; 1: sum = a - b - cin
//   out_valid / out_ready result handshake (sum, cout, ovf, zero)
//   cout                  carry-out; for subtraction 1 means no borrow
//   ovf                   signed overflow
//   zero                  sum == 0
module rca_seq_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSTEP = WIDTH / CHUNK;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SW-1:0]    step;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             c_r;

    logic             last;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   slice_res;
    logic [CHUNK-1:0] s_sl;
    logic             c_sl;
    logic             c_msb;
    logic [WIDTH-1:0] sum_nxt;

    assign last = (step == SW'(NSTEP - 1));

    // Current slice of the latched operands and its CHUNK+1 bit sum.
    assign a_sl      = a_r[int'(step) * CHUNK +: CHUNK];
    assign b_sl      = b_r[int'(step) * CHUNK +: CHUNK];
    assign slice_res = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, c_r};
    assign s_sl      = slice_res[CHUNK-1:0];
    assign c_sl      = slice_res[CHUNK];

    // Carry into the slice's top bit recovered from the sum bit: s = a ^ b ^ c_in.
    // On the last slice this is the carry into bit WIDTH-1.
    assign c_msb = s_sl[CHUNK-1] ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1];

    // Full result after this slice is written, used for the zero flag.
    always_comb begin
        sum_nxt = sum;
        sum_nxt[int'(step) * CHUNK +: CHUNK] = s_sl;
    end

    // Handshake outputs come straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
            a_r  <= '0;
            b_r  <= '0;
            c_r  <= 1'b0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction as a + ~b + ~borrow_in.
                        a_r  <= a;
                        b_r  <= sub ? ~b : b;
                        c_r  <= sub ? ~cin : cin;
                        step <= '0;
                        sum  <= '0;
                    end
                end
                CALC: begin
                    sum <= sum_nxt;
                    c_r <= c_sl;
                    if (last) begin
                        cout <= c_sl;
                        ovf  <= c_msb ^ c_sl;
                        zero <= (sum_nxt == '0);
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_adder.sv
module tb_rca_seq_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;          // 0: 32/8 instance, 1: 16/16 instance
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;

    logic        in_valid1, out_ready1, in_ready1, out_valid1, cout1, ovf1, zero1;
    logic [31:0] sum1;
    logic        in_valid2, out_ready2, in_ready2, out_valid2, cout2, ovf2, zero2;
    logic [15:0] sum2;

    logic        m_in_ready, m_out_valid, m_cout, m_ovf, m_zero;
    logic [31:0] m_sum;

    assign in_valid1  = in_valid & ~sel;
    assign out_ready1 = out_ready & ~sel;
    assign in_valid2  = in_valid & sel;
    assign out_ready2 = out_ready & sel;

    assign m_in_ready  = sel ? in_ready2  : in_ready1;
    assign m_out_valid = sel ? out_valid2 : out_valid1;
    assign m_sum       = sel ? {16'h0, sum2} : sum1;
    assign m_cout      = sel ? cout2 : cout1;
    assign m_ovf       = sel ? ovf2  : ovf1;
    assign m_zero      = sel ? zero2 : zero1;

    rca_seq_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    rca_seq_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic void model(input int w, input logic [31:0] ia, input logic [31:0] ib,
                                  input logic icin, input logic isub,
                                  output logic [31:0] s, output logic co, output logic ov,
                                  output logic z);
        longint m, ua, ub, ci, t, half, sa, sb, r;
        m    = (longint'(1) <<< w) - 1;
        ua   = longint'({32'h0, ia}) & m;
        ub   = longint'({32'h0, ib}) & m;
        ci   = icin ? 1 : 0;
        half = longint'(1) <<< (w - 1);
        if (isub) begin
            t  = ua - ub - ci;
            co = (t >= 0);
        end else begin
            t  = ua + ub + ci;
            co = ((t >>> w) & 1) != 0;
        end
        s  = 32'(t & m);
        z  = ((t & m) == 0);
        sa = (ua >= half) ? ua - 2 * half : ua;
        sb = (ub >= half) ? ub - 2 * half : ub;
        r  = isub ? (sa - sb - ci) : (sa + sb + ci);
        ov = (r >= half) || (r < -half);
    endfunction

    // Start one op, wait for out_valid (bounded), return results; ends on a negedge in DONE.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic icin,
                          input logic isub, input int nstep,
                          output logic [31:0] rs, output logic rco, output logic rov,
                          output logic rz);
        int n;
        @(negedge clk);
        chk("in_ready_before_accept", m_in_ready, 1);
        a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!m_out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n < nstep) chk("in_ready_low_in_calc", m_in_ready, 0);
        end
        chk("latency_edges", n, nstep);
        rs = m_sum; rco = m_cout; rov = m_ovf; rz = m_zero;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after_retire", m_in_ready, 1);
        chk("out_valid_after_retire", m_out_valid, 0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t        vt[7];
    logic [31:0] rs, es;
    logic        rco, rov, rz, eco, eov, ez;

    initial begin
        vt[0] = '{32'h3EBF3EBF, 32'h55555555, 1'b0, 1'b0, 32'h94149414, 1'b0, 1'b1, 1'b0};
        vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vt[3] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vt[4] = '{32'h00000007, 32'h00000007, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[5] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

        sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("reset_in_ready", m_in_ready, 1);
        chk("reset_out_valid", m_out_valid, 0);
        chk("reset_sum", m_sum, 0);
        chk("reset_flags", {m_cout, m_ovf, m_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors on the 32/8 instance.
        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, 4, rs, rco, rov, rz);
            chk($sformatf("vec%0d_sum", i), rs, vt[i].s);
            chk($sformatf("vec%0d_cout", i), rco, vt[i].co);
            chk($sformatf("vec%0d_ovf", i), rov, vt[i].ov);
            chk($sformatf("vec%0d_zero", i), rz, vt[i].z);
            retire();
        end

        // Backpressure: hold DONE while pulsing in_valid with other operands.
        run_op(vt[0].a, vt[0].b, 1'b0, 1'b0, 4, rs, rco, rov, rz);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", m_out_valid, 1);
            chk("bp_in_ready", m_in_ready, 0);
            chk("bp_sum", m_sum, 32'h94149414);
            chk("bp_flags", {m_cout, m_ovf, m_zero}, 3'b010);
        end
        in_valid = 1'b0;
        retire();
        chk("idle_holds_sum", m_sum, 32'h94149414);
        chk("idle_holds_ovf", m_ovf, 1);

        // Reset while in CALC at step 2.
        a = vt[0].a; b = vt[0].b; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("pre_reset_in_calc", m_in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", m_in_ready, 1);
        chk("midrst_out_valid", m_out_valid, 0);
        chk("midrst_sum", m_sum, 0);
        chk("midrst_flags", {m_cout, m_ovf, m_zero}, 0);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("no_accept_in_reset", m_in_ready, 1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        run_op(vt[0].a, vt[0].b, 1'b0, 1'b0, 4, rs, rco, rov, rz);
        chk("post_rst_sum", rs, 32'h94149414);
        chk("post_rst_flags", {rco, rov, rz}, 3'b010);
        retire();

        // Randomized ops on the 32/8 instance.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra, rb;
            logic rc, rsb;
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); rsb = 1'($urandom_range(0, 1));
            if (i % 8 == 0) begin rb = ra; rsb = 1'b1; rc = 1'b0; end
            if (i % 8 == 1) begin rb = ~ra; rsb = 1'b0; rc = 1'b1; end
            model(32, ra, rb, rc, rsb, es, eco, eov, ez);
            run_op(ra, rb, rc, rsb, 4, rs, rco, rov, rz);
            chk("rnd32_sum", rs, es);
            chk("rnd32_cout", rco, eco);
            chk("rnd32_ovf", rov, eov);
            chk("rnd32_zero", rz, ez);
            retire();
        end

        // 16/16 instance: single-cycle slice.
        sel = 1'b1;
        run_op(32'h7FFF, 32'h0, 1'b1, 1'b0, 1, rs, rco, rov, rz);
        chk("w16_sum", rs, 32'h8000);
        chk("w16_flags", {rco, rov, rz}, 3'b010);
        retire();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            logic rc, rsb;
            ra = $urandom & 32'hFFFF; rb = $urandom & 32'hFFFF;
            rc = 1'($urandom_range(0, 1)); rsb = 1'($urandom_range(0, 1));
            if (i % 10 == 0) begin rb = ra; rsb = 1'b1; rc = 1'b0; end
            model(16, ra, rb, rc, rsb, es, eco, eov, ez);
            run_op(ra, rb, rc, rsb, 1, rs, rco, rov, rz);
            chk("rnd16_sum", rs, es);
            chk("rnd16_cout", rco, eco);
            chk("rnd16_ovf", rov, eov);
            chk("rnd16_zero", rz, ez);
            retire();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
